// File: rtl/spw_light_rxbuf_pkg.sv
// rtl/spw_light_rxbuf_pkg.sv - shared sizes, marker codes and entry layout for the SpaceWire rx buffer
package spw_light_rxbuf_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int ENTRY_W   = 9;

  localparam logic [7:0] EOP_CODE = 8'h00;
  localparam logic [7:0] EEP_CODE = 8'h01;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
  } entry_t;
endpackage

// File: rtl/spw_light_rxbuf_if.sv
// rtl/spw_light_rxbuf_if.sv - SpaceWire receive side, consumer side and status signals of the rx buffer
interface spw_light_rxbuf_if #(
  parameter int AW = 4
);
  logic          spw_rxvalid;
  logic          spw_rxflag;
  logic [7:0]    spw_rxdata;
  logic          spw_rxread;
  logic          flush;
  logic          pop;
  logic [7:0]    out_data;
  logic          out_flag;
  logic          out_valid;
  logic [AW:0]   level;
  logic [AW:0]   pkt_count;
  logic          err_underflow;

  modport slave (
    input  spw_rxvalid, spw_rxflag, spw_rxdata, flush, pop,
    output spw_rxread, out_data, out_flag, out_valid, level, pkt_count, err_underflow
  );

  modport master (
    output spw_rxvalid, spw_rxflag, spw_rxdata, flush, pop,
    input  spw_rxread, out_data, out_flag, out_valid, level, pkt_count, err_underflow
  );
endinterface

// File: rtl/spw_light_rxbuf_ram.sv
// rtl/spw_light_rxbuf_ram.sv - DEPTH x 9 storage, one write port, asynchronous read port
module spw_light_rxbuf_ram
  import spw_light_rxbuf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);
  entry_t mem_q [DEPTH];

  // Contents are never reset; validity is tracked by the controller's level.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/spw_light_rxbuf.sv
// rtl/spw_light_rxbuf.sv - first-word fall-through receive FIFO between a SpaceWire core and a CPU PIO port
module spw_light_rxbuf
  import spw_light_rxbuf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  spw_light_rxbuf_if.slave  bus
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d, pkt_q, pkt_d;
  logic          err_q, err_d;
  logic          empty, full, push, pop_ok;
  entry_t        head, wr_entry;

  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LVL);
  assign push     = bus.spw_rxvalid && bus.spw_rxread;
  assign pop_ok   = bus.pop && !empty;
  assign wr_entry = '{flag: bus.spw_rxflag, data: bus.spw_rxdata};

  spw_light_rxbuf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    err_d    = err_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      pkt_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (bus.pop && empty) err_d = 1'b1;
      case ({push, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // Marker count moves only when exactly one marker enters or leaves.
      case ({push && bus.spw_rxflag, pop_ok && head.flag})
        2'b10:   pkt_d = pkt_q + 1'b1;
        2'b01:   pkt_d = pkt_q - 1'b1;
        default: pkt_d = pkt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
    end
  end

  assign bus.spw_rxread    = !full && !bus.flush;
  assign bus.out_valid     = !empty;
  assign bus.out_data      = empty ? 8'h00 : head.data;
  assign bus.out_flag      = !empty && head.flag;
  assign bus.level         = level_q;
  assign bus.pkt_count     = pkt_q;
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_spw_light_rxbuf.sv
// tb/tb_spw_light_rxbuf.sv - randomized self-checking bench for spw_light_rxbuf against a queue model
module tb_spw_light_rxbuf;
  import spw_light_rxbuf_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [8:0] mq[$];
  logic       merr = 1'b0;

  spw_light_rxbuf_if #(.AW(AW)) b ();

  spw_light_rxbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  function automatic int mpkt();
    int n = 0;
    foreach (mq[i]) if (mq[i][8]) n++;
    return n;
  endfunction

  function automatic logic [7:0] mhead_data();
    logic [8:0] e;
    if (mq.size() == 0) return 8'h00;
    e = mq[0];
    return e[7:0];
  endfunction

  function automatic logic mhead_flag();
    logic [8:0] e;
    if (mq.size() == 0) return 1'b0;
    e = mq[0];
    return e[8];
  endfunction

  // Advances one clock and applies the buffer rules to the model using pre-edge inputs.
  task automatic tick();
    logic       acc, do_pop, do_flush;
    logic [8:0] ent;
    acc      = b.spw_rxvalid && (mq.size() != DEPTH) && !b.flush;
    do_pop   = b.pop;
    do_flush = b.flush;
    ent      = {b.spw_rxflag, b.spw_rxdata};
    @(posedge clk);
    if (do_flush) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      if (do_pop) begin
        if (mq.size() != 0) void'(mq.pop_front());
        else merr = 1'b1;
      end
      if (acc) mq.push_back(ent);
    end
    #1;
  endtask

  task automatic idle_inputs();
    b.spw_rxvalid = 1'b0;
    b.spw_rxflag  = 1'b0;
    b.spw_rxdata  = 8'h00;
    b.pop         = 1'b0;
    b.flush       = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    b.flush = 1'b1;
    tick();
    b.flush = 1'b0;
    #1;
  endtask

  task automatic push_one(input logic flag, input logic [7:0] data);
    b.spw_rxvalid = 1'b1;
    b.spw_rxflag  = flag;
    b.spw_rxdata  = data;
    tick();
    b.spw_rxvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    merr = 1'b0;
    #1;
    total++; if (b.level !== 5'd0) begin bad++; $display("FAIL reset_level got %0d want 0", b.level); end
    total++; if (b.pkt_count !== 5'd0) begin bad++; $display("FAIL reset_pkt got %0d want 0", b.pkt_count); end
    total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", b.out_valid); end
    total++; if ({b.out_flag, b.out_data} !== 9'h000) begin bad++; $display("FAIL reset_out got %0h want 0", {b.out_flag, b.out_data}); end
    total++; if (b.err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err got %0b want 0", b.err_underflow); end
    total++; if (b.spw_rxread !== 1'b1) begin bad++; $display("FAIL reset_rxread got %0b want 1", b.spw_rxread); end
  endtask

  task automatic test_basic();
    push_one(1'b0, 8'h41);
    total++; if (b.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %0b want 1", b.out_valid); end
    total++; if (b.out_data !== 8'h41) begin bad++; $display("FAIL basic_head got %0h want 41", b.out_data); end
    push_one(1'b0, 8'h42);
    push_one(1'b1, EOP_CODE);
    total++; if (b.level !== 5'd3) begin bad++; $display("FAIL basic_level got %0d want 3", b.level); end
    total++; if (b.pkt_count !== 5'd1) begin bad++; $display("FAIL basic_pkt got %0d want 1", b.pkt_count); end
    total++; if (b.out_data !== 8'h41) begin bad++; $display("FAIL basic_head2 got %0h want 41", b.out_data); end
  endtask

  task automatic test_full();
    do_flush();
    b.spw_rxvalid = 1'b1;
    b.spw_rxflag  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b.spw_rxdata = 8'(i);
      tick();
    end
    total++; if (b.spw_rxread !== 1'b0) begin bad++; $display("FAIL full_rxread got %0b want 0", b.spw_rxread); end
    total++; if (b.level !== 5'd16) begin bad++; $display("FAIL full_level got %0d want 16", b.level); end
    b.spw_rxdata = 8'hAA;
    b.pop = 1'b1;
    tick();
    b.pop = 1'b0;
    #1;
    total++; if (b.spw_rxread !== 1'b1) begin bad++; $display("FAIL full_rxread_after_pop got %0b want 1", b.spw_rxread); end
    total++; if (b.level !== 5'd15) begin bad++; $display("FAIL full_level_after_pop got %0d want 15", b.level); end
    tick();
    b.spw_rxvalid = 1'b0;
    total++; if (b.level !== 5'd16) begin bad++; $display("FAIL full_17th_level got %0d want 16", b.level); end
    total++; if (b.out_data !== 8'h01) begin bad++; $display("FAIL full_head got %0h want 01", b.out_data); end
    total++; if (mq[DEPTH-1] !== 9'h0AA) begin bad++; $display("FAIL full_model_tail got %0h want aa", mq[DEPTH-1]); end
  endtask

  task automatic test_underflow();
    do_flush();
    b.pop = 1'b1;
    tick();
    b.pop = 1'b0;
    total++; if (b.err_underflow !== 1'b1) begin bad++; $display("FAIL uflow_err got %0b want 1", b.err_underflow); end
    total++; if (b.level !== 5'd0) begin bad++; $display("FAIL uflow_level got %0d want 0", b.level); end
    do_flush();
    total++; if (b.err_underflow !== 1'b0) begin bad++; $display("FAIL uflow_flush got %0b want 0", b.err_underflow); end
  endtask

  task automatic test_simul();
    logic [7:0] vals[6];
    do_flush();
    for (int i = 0; i < 5; i++) begin
      vals[i] = 8'($urandom_range(2, 255));
      push_one(1'b0, vals[i]);
    end
    vals[5] = 8'h7E;
    b.spw_rxvalid = 1'b1;
    b.spw_rxdata  = 8'h7E;
    b.pop         = 1'b1;
    tick();
    idle_inputs();
    total++; if (b.level !== 5'd5) begin bad++; $display("FAIL simul_level got %0d want 5", b.level); end
    for (int i = 1; i < 6; i++) begin
      total++; if (b.out_data !== vals[i]) begin bad++; $display("FAIL simul_order%0d got %0h want %0h", i, b.out_data, vals[i]); end
      b.pop = 1'b1;
      tick();
      b.pop = 1'b0;
    end
    total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL simul_empty got %0b want 0", b.out_valid); end
  endtask

  task automatic test_wrap();
    int exp_idx = 0;
    int guard = 0;
    do_flush();
    for (int i = 0; i < 20; i++) begin
      b.spw_rxvalid = 1'b1;
      b.spw_rxdata  = 8'(i);
      b.pop         = (i >= 4);
      if (b.pop) begin
        total++; if (b.out_data !== 8'(exp_idx)) begin bad++; $display("FAIL wrap_order got %0h want %0h", b.out_data, exp_idx); end
        exp_idx++;
      end
      tick();
    end
    b.spw_rxvalid = 1'b0;
    b.pop = 1'b1;
    while (exp_idx < 20 && guard < 40) begin
      total++; if (b.out_data !== 8'(exp_idx)) begin bad++; $display("FAIL wrap_drain got %0h want %0h", b.out_data, exp_idx); end
      exp_idx++;
      guard++;
      tick();
    end
    b.pop = 1'b0;
    total++; if (b.pkt_count !== 5'd0) begin bad++; $display("FAIL wrap_pkt got %0d want 0", b.pkt_count); end
    total++; if (b.level !== 5'd0) begin bad++; $display("FAIL wrap_level got %0d want 0", b.level); end
  endtask

  task automatic test_reset_mid();
    do_flush();
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 6) push_one(1'b1, EEP_CODE);
      else push_one(1'b0, 8'(8'h30 + i));
    end
    total++; if (b.pkt_count !== 5'd2) begin bad++; $display("FAIL rmid_pre_pkt got %0d want 2", b.pkt_count); end
    b.spw_rxvalid = 1'b1;
    b.spw_rxdata  = 8'h99;
    #2;
    reset = 1'b1;
    mq.delete();
    merr = 1'b0;
    #1;
    total++; if (b.level !== 5'd0) begin bad++; $display("FAIL rmid_level got %0d want 0", b.level); end
    total++; if (b.pkt_count !== 5'd0) begin bad++; $display("FAIL rmid_pkt got %0d want 0", b.pkt_count); end
    total++; if ({b.out_valid, b.out_flag, b.out_data} !== 10'h000) begin bad++; $display("FAIL rmid_out got %0h want 0", {b.out_valid, b.out_flag, b.out_data}); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    b.spw_rxdata = 8'h5A;
    tick();
    b.spw_rxvalid = 1'b0;
    total++; if (b.level !== 5'd1) begin bad++; $display("FAIL rmid_first_push got %0d want 1", b.level); end
    total++; if (b.out_data !== 8'h5A) begin bad++; $display("FAIL rmid_head got %0h want 5a", b.out_data); end
  endtask

  task automatic test_random();
    int pop_pct;
    do_flush();
    for (int c = 0; c < 600; c++) begin
      pop_pct = (c < 200) ? 25 : (c < 400) ? 80 : 50;
      b.spw_rxvalid = ($urandom_range(0, 99) < 70);
      b.spw_rxflag  = ($urandom_range(0, 99) < 15);
      b.spw_rxdata  = b.spw_rxflag ? 8'($urandom_range(0, 3)) : 8'($urandom);
      b.pop         = ($urandom_range(0, 99) < pop_pct);
      b.flush       = ($urandom_range(0, 99) < 2);
      tick();
      total++;
      if (b.level !== 5'(mq.size()) || b.pkt_count !== 5'(mpkt()) ||
          b.out_valid !== (mq.size() != 0) || b.out_data !== mhead_data() ||
          b.out_flag !== mhead_flag() || b.err_underflow !== merr ||
          b.spw_rxread !== ((mq.size() != DEPTH) && !b.flush)) begin
        bad++;
        $display("FAIL random_c%0d got lvl=%0d pkt=%0d v=%0b d=%0h f=%0b e=%0b rr=%0b want lvl=%0d pkt=%0d d=%0h f=%0b e=%0b",
                 c, b.level, b.pkt_count, b.out_valid, b.out_data, b.out_flag, b.err_underflow, b.spw_rxread,
                 mq.size(), mpkt(), mhead_data(), mhead_flag(), merr);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_simul();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
